// File: rtl/return_stack_if.sv
// Return-stack request/status bundle: push/pop/flush/error-clear requests
// towards the stack and the registered top, count and flag outputs back.
interface return_stack_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    logic                       push_i;
    logic                       pop_i;
    logic                       flush_i;
    logic                       err_clr_i;
    logic [DATA_WIDTH-1:0]      data_i;
    logic [DATA_WIDTH-1:0]      top_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       empty_o;
    logic                       full_o;
    logic                       ovf_o;
    logic                       unf_o;

    modport master (
        output push_i, pop_i, flush_i, err_clr_i, data_i,
        input  top_o, count_o, empty_o, full_o, ovf_o, unf_o
    );

    modport slave (
        input  push_i, pop_i, flush_i, err_clr_i, data_i,
        output top_o, count_o, empty_o, full_o, ovf_o, unf_o
    );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack: circular buffer addressed by base pointer + count.
// Define RSTACK_WRAP_EN to let a push on a full stack overwrite the oldest entry.
module return_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    return_stack_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("return_stack: DEPTH must be a power of two between 2 and 256");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] top_q, top_d;
    cnt_t                  count_q, count_d;
    ptr_t                  base_q, base_d;
    logic                  ovf_q, unf_q;
    logic                  ovf_evt, unf_evt;
    logic                  mem_we;
    ptr_t                  mem_widx;
    ptr_t                  wr_idx, top_idx, below_idx;
    logic                  empty, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(DEPTH));

    // At count==DEPTH the truncated count is 0, so wr_idx lands on the oldest entry.
    assign wr_idx    = base_q + ptr_t'(count_q);
    assign top_idx   = wr_idx - ptr_t'(1);
    assign below_idx = wr_idx - ptr_t'(2);

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        count_d  = count_q;
        top_d    = top_q;
        base_d   = base_q;
        mem_we   = 1'b0;
        mem_widx = wr_idx;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (bus.flush_i) begin
            count_d = '0;
            top_d   = '0;
        end else if (bus.push_i && (!bus.pop_i || empty)) begin
            if (!full) begin
                mem_we  = 1'b1;
                count_d = count_q + cnt_t'(1);
                top_d   = bus.data_i;
            end else begin
                ovf_evt = 1'b1;
`ifdef RSTACK_WRAP_EN
                mem_we  = 1'b1;
                base_d  = base_q + ptr_t'(1);
                top_d   = bus.data_i;
`endif
            end
        end else if (bus.push_i && bus.pop_i) begin
            mem_we   = 1'b1;
            mem_widx = top_idx;
            top_d    = bus.data_i;
        end else if (bus.pop_i) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                count_d = count_q - cnt_t'(1);
                top_d   = (count_q == cnt_t'(1)) ? '0 : mem[below_idx];
            end
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
            top_q   <= '0;
            base_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            base_q  <= base_d;
            ovf_q   <= (ovf_q && !bus.err_clr_i) || ovf_evt;
            unf_q   <= (unf_q && !bus.err_clr_i) || unf_evt;
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q alone defines validity.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_widx] <= bus.data_i;
        end
    end

    assign bus.top_o   = top_q;
    assign bus.count_o = count_q;
    assign bus.empty_o = empty;
    assign bus.full_o  = full;
    assign bus.ovf_o   = ovf_q;
    assign bus.unf_o   = unf_q;
endmodule
